// File: rtl/rcvbuf_pkg.sv
// Shared constants and width helpers for the receive bit buffer.
// Widths are derived from the FIFO depth so every file sizes pointers the same way.
package rcvbuf_pkg;

    localparam int   RCVBUF_DATA_W = 8;
    localparam int   RCVBUF_DEPTH  = 1250;
    localparam logic RCVBUF_IDLE   = 1'b1;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rcvbitbuf_if.sv
// Word-in / bit-out signal bundle of the receive bit buffer.
// The slave side is the buffer; the master side is the UART receiver plus bit-rate logic.
interface rcvbitbuf_if
    import rcvbuf_pkg::*;
#(
    parameter int DATA_W = RCVBUF_DATA_W,
    parameter int CNT_W  = cnt_w(RCVBUF_DEPTH)
) ();

    logic              newdata;
    logic [DATA_W-1:0] rbr;
    logic              bit_tick;
    logic              flush;
    logic              databit;
    logic              bit_valid;
    logic [CNT_W-1:0]  word_count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underrun;

    modport master (
        output newdata, rbr, bit_tick, flush,
        input  databit, bit_valid, word_count, full, empty, overflow, underrun
    );

    modport slave (
        input  newdata, rbr, bit_tick, flush,
        output databit, bit_valid, word_count, full, empty, overflow, underrun
    );

endinterface

// File: rtl/rcvbuf_ram.sv
// Simple dual-port word RAM: synchronous write, registered read, no array reset.
// Read-during-write to the same address returns the old word; the caller bypasses that case.
module rcvbuf_ram
    import rcvbuf_pkg::*;
#(
    parameter int DATA_W = RCVBUF_DATA_W,
    parameter int DEPTH  = RCVBUF_DEPTH,
    parameter int ADDR_W = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/rcvbitbuf.sv
// Receive bit buffer: rising-edge word capture into a circular FIFO, serialised one bit per tick.
// The FIFO head is always presented combinationally so a pop on any tick needs no wait state.
module rcvbitbuf
    import rcvbuf_pkg::*;
#(
    parameter int   DATA_W    = RCVBUF_DATA_W,
    parameter int   DEPTH     = RCVBUF_DEPTH,
    parameter bit   MSB_FIRST = 1'b0,
    parameter logic IDLE_BIT  = RCVBUF_IDLE
) (
    input logic       rcvbuf_clk,
    input logic       reset,
    rcvbitbuf_if.slave bus
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int BL_W  = $clog2(DATA_W + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [BL_W-1:0]  BL_RELOAD = BL_W'(DATA_W - 1);

    logic              r_newdata_q;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_byp_sel;
    logic [DATA_W-1:0] r_byp_data;
    logic [DATA_W-1:0] r_shift;
    logic [BL_W-1:0]   r_bits_left;
    logic              r_databit;
    logic              r_bit_valid;
    logic              r_sent;
    logic              r_overflow;
    logic              r_underrun;

    logic              w_wr_req;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_drop;
    logic [PTR_W-1:0]  w_rd_addr;
    logic [DATA_W-1:0] w_ram_q;
    logic [DATA_W-1:0] w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_wr_req  = bus.newdata & ~r_newdata_q;
        w_full    = (r_count == CNT_FULL);
        w_empty   = (r_count == '0);
        w_pop     = bus.bit_tick & (r_bits_left == '0) & ~w_empty & ~bus.flush;
        w_wr_en   = w_wr_req & (~w_full | w_pop) & ~bus.flush;
        w_drop    = w_wr_req & w_full & ~w_pop & ~bus.flush;
        // Read the address that will be the head next cycle, so the RAM output tracks rd_ptr.
        w_rd_addr = (reset | bus.flush) ? '0 : (w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr);
        w_head    = r_byp_sel ? r_byp_data : w_ram_q;
    end

    rcvbuf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (rcvbuf_clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.rbr),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_q)
    );

    // Edge detector keeps tracking through flush so a held newdata does not rewrite afterwards.
    always_ff @(posedge rcvbuf_clk) begin
        if (reset) begin
            r_newdata_q <= 1'b0;
        end else begin
            r_newdata_q <= bus.newdata;
        end
    end

    always_ff @(posedge rcvbuf_clk) begin
        r_byp_data <= bus.rbr;
    end

    always_ff @(posedge rcvbuf_clk) begin
        if (reset || bus.flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_byp_sel   <= 1'b0;
            r_shift     <= '0;
            r_bits_left <= '0;
            r_databit   <= IDLE_BIT;
            r_bit_valid <= 1'b0;
            r_sent      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A write landing on the address being read would come back stale from the RAM.
            r_byp_sel <= w_wr_en && (r_wr_ptr == w_rd_addr);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (bus.bit_tick) begin
                if (r_bits_left != '0) begin
                    r_bits_left <= r_bits_left - BL_W'(1);
                    r_bit_valid <= 1'b1;
                    r_sent      <= 1'b1;
                    if (MSB_FIRST) begin
                        r_databit <= r_shift[DATA_W-1];
                        r_shift   <= r_shift << 1;
                    end else begin
                        r_databit <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                    end
                end else if (w_pop) begin
                    r_bits_left <= BL_RELOAD;
                    r_bit_valid <= 1'b1;
                    r_sent      <= 1'b1;
                    if (MSB_FIRST) begin
                        r_databit <= w_head[DATA_W-1];
                        r_shift   <= w_head << 1;
                    end else begin
                        r_databit <= w_head[0];
                        r_shift   <= w_head >> 1;
                    end
                end else begin
                    r_databit   <= IDLE_BIT;
                    r_bit_valid <= 1'b0;
                    if (r_sent) begin
                        r_underrun <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.databit    = r_databit;
    assign bus.bit_valid  = r_bit_valid;
    assign bus.word_count = r_count;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.overflow   = r_overflow;
    assign bus.underrun   = r_underrun;

endmodule

// File: tb/tb_rcvbitbuf.sv
// Scoreboard bench: two buffers (LSB-first and MSB-first, depth 4) share one stimulus stream.
// Expected bits are queued when words are written; a monitor pops them on every serviced tick.
module tb_rcvbitbuf;
    import rcvbuf_pkg::*;

    localparam int DW  = 8;
    localparam int DEP = 4;
    localparam int CW  = cnt_w(DEP);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rcvbitbuf_if #(.DATA_W(DW), .CNT_W(CW)) bus_a ();
    rcvbitbuf_if #(.DATA_W(DW), .CNT_W(CW)) bus_b ();

    assign bus_b.newdata  = bus_a.newdata;
    assign bus_b.rbr      = bus_a.rbr;
    assign bus_b.bit_tick = bus_a.bit_tick;
    assign bus_b.flush    = bus_a.flush;

    rcvbitbuf #(.DATA_W(DW), .DEPTH(DEP), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_lsb (
        .rcvbuf_clk (clk),
        .reset      (rst),
        .bus        (bus_a)
    );

    rcvbitbuf #(.DATA_W(DW), .DEPTH(DEP), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_dut_msb (
        .rcvbuf_clk (clk),
        .reset      (rst),
        .bus        (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    bit qa[$];
    bit qb[$];
    bit mon_tick;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) qa.push_back(w[i]);
        for (int i = DW - 1; i >= 0; i--) qb.push_back(w[i]);
    endtask

    task automatic wr(input logic [DW-1:0] w, input int hold, input bit accepted);
        bus_a.newdata = 1'b1;
        bus_a.rbr     = w;
        if (accepted) push_word(w);
        repeat (hold) @(negedge clk);
        bus_a.newdata = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bus_a.bit_tick = 1'b1;
            @(negedge clk);
            bus_a.bit_tick = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic do_flush();
        bus_a.flush = 1'b1;
        @(negedge clk);
        bus_a.flush = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    // Monitor: every tick the DUT acts on yields one registered bit one cycle later.
    initial begin
        forever begin
            @(posedge clk);
            mon_tick = bus_a.bit_tick && !bus_a.flush && !rst;
            #1;
            if (mon_tick) begin
                if (bus_a.bit_valid) begin
                    n_valid++;
                    if (qa.size() == 0) chk("lsb_unexpected_bit", qa.size(), 1);
                    else chk("lsb_bit", bus_a.databit, qa.pop_front());
                end else begin
                    chk("lsb_idle_bit", bus_a.databit, 1);
                end
                if (bus_b.bit_valid) begin
                    if (qb.size() == 0) chk("msb_unexpected_bit", qb.size(), 1);
                    else chk("msb_bit", bus_b.databit, qb.pop_front());
                end else begin
                    chk("msb_idle_bit", bus_b.databit, 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus_a.newdata  = 1'b0;
        bus_a.rbr      = '0;
        bus_a.bit_tick = 1'b0;
        bus_a.flush    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_databit",    bus_a.databit, 1);
        chk("rst_bit_valid",  bus_a.bit_valid, 0);
        chk("rst_word_count", bus_a.word_count, 0);
        chk("rst_full",       bus_a.full, 0);
        chk("rst_empty",      bus_a.empty, 1);
        chk("rst_overflow",   bus_a.overflow, 0);
        chk("rst_underrun",   bus_a.underrun, 0);

        tick(1, 0);
        chk("tick_after_rst_underrun", bus_a.underrun, 0);
        chk("tick_after_rst_valid",    bus_a.bit_valid, 0);

        // Basic serialisation, with newdata held high for 20 cycles per word.
        wr(8'hF0, 20, 1'b1);
        chk("t1_count_after_w1", bus_a.word_count, 1);
        wr(8'h55, 20, 1'b1);
        chk("t1_count_after_w2", bus_a.word_count, 2);
        n_valid = 0;
        tick(1, 2);
        chk("t1_count_pop1", bus_a.word_count, 1);
        tick(7, 1);
        chk("t1_count_mid", bus_a.word_count, 1);
        tick(1, 0);
        chk("t1_count_pop2", bus_a.word_count, 0);
        tick(7, 0);
        chk("t1_underrun_before_drain", bus_a.underrun, 0);
        tick(1, 0);
        chk("t4_underrun",   bus_a.underrun, 1);
        chk("t4_bit_valid",  bus_a.bit_valid, 0);
        chk("t4_databit",    bus_a.databit, 1);
        chk("t1_valid_bits", n_valid, 16);
        chk("t1_queue_drained", qa.size(), 0);

        // Overflow at depth 4.
        do_flush();
        chk("t3_flush_empty",    bus_a.empty, 1);
        chk("t3_flush_underrun", bus_a.underrun, 0);
        wr(8'hA1, 2, 1'b1);
        wr(8'hB2, 2, 1'b1);
        wr(8'hC3, 2, 1'b1);
        wr(8'hD4, 2, 1'b1);
        chk("t3_full",        bus_a.full, 1);
        chk("t3_no_overflow", bus_a.overflow, 0);
        wr(8'hE5, 2, 1'b0);
        chk("t3_overflow",    bus_a.overflow, 1);
        chk("t3_count_full",  bus_a.word_count, 4);
        n_valid = 0;
        tick(33, 0);
        chk("t3_valid_bits", n_valid, 32);
        chk("t3_empty",      bus_a.empty, 1);
        chk("t3_overflow_sticky", bus_a.overflow, 1);

        // Write edge coincides with a popping tick while full; then pointers wrap.
        do_flush();
        wr(8'h11, 2, 1'b1);
        wr(8'h22, 2, 1'b1);
        wr(8'h33, 2, 1'b1);
        wr(8'h44, 2, 1'b1);
        chk("t5_full_before", bus_a.full, 1);
        bus_a.newdata  = 1'b1;
        bus_a.rbr      = 8'h55;
        bus_a.bit_tick = 1'b1;
        push_word(8'h55);
        @(negedge clk);
        bus_a.bit_tick = 1'b0;
        chk("t5_count_same", bus_a.word_count, 4);
        chk("t5_overflow",   bus_a.overflow, 0);
        repeat (3) @(negedge clk);
        bus_a.newdata = 1'b0;
        @(negedge clk);
        tick(7, 1);
        chk("t5_count_after_word", bus_a.word_count, 4);
        tick(32, 0);
        chk("t5_count_drained", bus_a.word_count, 0);
        wr(8'h66, 2, 1'b1);
        tick(9, 0);
        chk("t5_queue_drained", qa.size(), 0);
        chk("t5_underrun",      bus_a.underrun, 1);

        // Flush mid-word.
        do_flush();
        tick(1, 0);
        chk("t6_tick_after_flush_underrun", bus_a.underrun, 0);
        wr(8'hA5, 2, 1'b1);
        tick(3, 0);
        bus_a.flush = 1'b1;
        @(negedge clk);
        bus_a.flush = 1'b0;
        qa.delete();
        qb.delete();
        chk("t6_empty",     bus_a.empty, 1);
        chk("t6_databit",   bus_a.databit, 1);
        chk("t6_bit_valid", bus_a.bit_valid, 0);
        wr(8'h3C, 2, 1'b1);
        n_valid = 0;
        tick(9, 0);
        chk("t6_valid_bits", n_valid, 8);
        chk("t6_queue_drained", qa.size(), 0);

        // newdata held high through reset release gives exactly one write.
        rst           = 1'b1;
        bus_a.newdata = 1'b1;
        bus_a.rbr     = 8'h81;
        qa.delete();
        qb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_word(8'h81);
        @(negedge clk);
        chk("rst_held_count", bus_a.word_count, 1);
        repeat (2) @(negedge clk);
        bus_a.newdata = 1'b0;
        @(negedge clk);
        chk("rst_held_single_write", bus_a.word_count, 1);
        tick(8, 0);
        chk("rst_held_drained", bus_a.word_count, 0);
        tick(1, 0);
        chk("rst_held_underrun", bus_a.underrun, 1);
        chk("rst_held_queue",    qa.size(), 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
